// File: rtl/coef_value_decoder.sv
// Streaming JPEG size/amplitude decoder: sign-extends amplitude bits, then adds
// DC differences to a per-component predictor with saturation. Two-stage valid/ready pipe.
module coef_value_decoder #(
  parameter int SIZE_WIDTH = 4,
  parameter int CODE_WIDTH = 12,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_COMP   = 3,
  parameter int COMP_W     = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE_WIDTH-1:0] in_size,
  input  logic [CODE_WIDTH-1:0] in_code,
  input  logic                  in_is_dc,
  input  logic [COMP_W-1:0]     in_comp,
  input  logic                  pred_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_value,
  output logic [COMP_W-1:0]     out_comp,
  output logic                  out_is_dc,
  output logic                  out_err,
  output logic                  out_sat
);

  localparam logic [OUT_WIDTH-1:0] ONES    = '1;
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                 en1, en2;
  logic                 s1_valid, s1_err, s1_is_dc;
  logic [OUT_WIDTH-1:0] s1_e;
  logic [COMP_W-1:0]    s1_comp;
  logic [OUT_WIDTH-1:0] pred [NUM_COMP];

  logic [OUT_WIDTH-1:0] mask, mag, top, ext;
  logic                 in_err, neg;
  logic [OUT_WIDTH-1:0] pred_sel, dc_val, nxt_val;
  logic [OUT_WIDTH:0]   sum;
  logic                 ovf, nxt_sat, pred_we;

  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  // mask covers the low s bits; top isolates bit s-1 (zero when s = 0, which makes ext = 0)
  always_comb begin
    in_err = {{(32-SIZE_WIDTH){1'b0}}, in_size} > 32'(CODE_WIDTH);
    mask   = ~(ONES << in_size);
    mag    = OUT_WIDTH'(in_code) & mask;
    top    = mask & ~(mask >> 1);
    neg    = ((mag & top) == '0);
    ext    = '0;
    if (!in_err) ext = neg ? (mag - mask) : mag;
  end

  always_comb begin
    pred_sel = '0;
    for (int i = 0; i < NUM_COMP; i++)
      if (s1_comp == COMP_W'(i)) pred_sel = pred[i];
    sum     = {s1_e[OUT_WIDTH-1], s1_e} + {pred_sel[OUT_WIDTH-1], pred_sel};
    ovf     = sum[OUT_WIDTH] ^ sum[OUT_WIDTH-1];
    dc_val  = ovf ? (sum[OUT_WIDTH] ? SAT_MIN : SAT_MAX) : sum[OUT_WIDTH-1:0];
    nxt_val = s1_err ? '0 : (s1_is_dc ? dc_val : s1_e);
    nxt_sat = !s1_err && s1_is_dc && ovf;
    pred_we = en2 && s1_valid && s1_is_dc && !s1_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_e     <= '0;
      s1_err   <= 1'b0;
      s1_is_dc <= 1'b0;
      s1_comp  <= '0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_e     <= ext;
        s1_err   <= in_err;
        s1_is_dc <= in_is_dc;
        s1_comp  <= in_comp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_comp  <= '0;
      out_is_dc <= 1'b0;
      out_err   <= 1'b0;
      out_sat   <= 1'b0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_value <= nxt_val;
        out_comp  <= s1_comp;
        out_is_dc <= s1_is_dc;
        out_err   <= s1_err;
        out_sat   <= nxt_sat;
      end
    end
  end

  // clear has priority over a same-cycle update; the result itself still used the old predictor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COMP; i++) pred[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_COMP; i++) begin
        if (pred_clear) pred[i] <= '0;
        else if (pred_we && s1_comp == COMP_W'(i)) pred[i] <= nxt_val;
      end
    end
  end

endmodule

// File: tb/tb_coef_value_decoder.sv
// Bench for coef_value_decoder: two instances (16-bit and 13-bit outputs) share one
// input stream; an accept-ordered arithmetic model predicts every transferred result.
module tb_coef_value_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_size = '0;
  logic [11:0] in_code = '0;
  logic        in_is_dc = 1'b0;
  logic [1:0]  in_comp = '0;
  logic        pred_clear = 1'b0;
  logic        out_ready = 1'b1;

  logic        rdy_a, ov_a, dc_a, err_a, sat_a;
  logic [15:0] val_a;
  logic [1:0]  comp_a;
  logic        rdy_b, ov_b, dc_b, err_b, sat_b;
  logic [12:0] val_b;
  logic [1:0]  comp_b;

  coef_value_decoder dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_size(in_size), .in_code(in_code), .in_is_dc(in_is_dc), .in_comp(in_comp),
    .pred_clear(pred_clear), .out_valid(ov_a), .out_ready(out_ready),
    .out_value(val_a), .out_comp(comp_a), .out_is_dc(dc_a), .out_err(err_a), .out_sat(sat_a));

  coef_value_decoder #(.OUT_WIDTH(13)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_size(in_size), .in_code(in_code), .in_is_dc(in_is_dc), .in_comp(in_comp),
    .pred_clear(pred_clear), .out_valid(ov_b), .out_ready(out_ready),
    .out_value(val_b), .out_comp(comp_b), .out_is_dc(dc_b), .out_err(err_b), .out_sat(sat_b));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int va; int vb; int comp; bit dc; bit err; bit sa; bit sb;
  } exp_t;

  exp_t exp_q[$];
  int   pa[3], pb[3];
  int   log_a[$], log_b[$];
  bit   log_eb[$], log_sb[$];
  int   bp_mode = 0;
  int   cyc = 0;
  logic [3:0] bp_pat = 4'b1001;

  function automatic int ext_val(int s, int code);
    int v;
    if (s == 0) return 0;
    v = code & ((1 << s) - 1);
    if (((v >> (s - 1)) & 1) == 1) return v;
    return v - ((1 << s) - 1);
  endfunction

  function automatic int clip(int x, int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // reference model and scoreboard, evaluated mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("in_ready", int'(rdy_a), int'(!(exp_q.size() == 2 && !out_ready)));
      chk("in_ready_b", int'(rdy_b), int'(rdy_a));
      if (pred_clear) begin
        pa = '{0, 0, 0};
        pb = '{0, 0, 0};
      end
      if (in_valid && rdy_a) begin
        int s, x, c, sa, sb;
        s = int'(in_size);
        c = int'(in_comp);
        e.err = (s > 12);
        x = e.err ? 0 : ext_val(s, int'(in_code));
        e.comp = c;
        e.dc = in_is_dc;
        e.va = x; e.vb = x; e.sa = 0; e.sb = 0;
        if (in_is_dc && !e.err) begin
          sa = pa[c] + x;
          sb = pb[c] + x;
          e.va = clip(sa, 16); e.sa = (e.va != sa);
          e.vb = clip(sb, 13); e.sb = (e.vb != sb);
          pa[c] = e.va;
          pb[c] = e.vb;
        end
        exp_q.push_back(e);
      end
      if (ov_a && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("val16", int'($signed(val_a)), e.va);
          chk("sat16", int'(sat_a), int'(e.sa));
          chk("err16", int'(err_a), int'(e.err));
          chk("comp16", int'(comp_a), e.comp);
          chk("dc16", int'(dc_a), int'(e.dc));
          chk("ov13", int'(ov_b), 1);
          chk("val13", int'($signed(val_b)), e.vb);
          chk("sat13", int'(sat_b), int'(e.sb));
          chk("err13", int'(err_b), int'(e.err));
          chk("comp13", int'(comp_b), e.comp);
        end
        log_a.push_back(int'($signed(val_a)));
        log_b.push_back(int'($signed(val_b)));
        log_eb.push_back(err_b);
        log_sb.push_back(sat_b);
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bp_mode == 1) out_ready = bp_pat[cyc % 4];
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int s, input int code, input bit dc, input int comp);
    int  n = 0;
    bit  acc;
    in_valid = 1'b1;
    in_size  = 4'(s);
    in_code  = 12'(code);
    in_is_dc = dc;
    in_comp  = 2'(comp);
    do begin
      @(negedge clk);
      acc = rdy_a;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 30) begin step(1); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    step(1);
  endtask

  task automatic clear_log();
    log_a.delete(); log_b.delete(); log_eb.delete(); log_sb.delete();
  endtask

  task automatic chk_log(input string tag, input int idx, input int exp);
    if (idx < log_a.size()) chk(tag, log_a[idx], exp);
    else chk({tag, "_missing"}, log_a.size(), idx + 1);
  endtask

  int ac_s[6]    = '{1, 2, 1, 2, 4, 0};
  int ac_c[6]    = '{0, 0, 1, 1, 5, 5};
  int ac_exp[6]  = '{-1, -3, 1, -2, -10, 0};
  int bp_s[8], bp_c[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    chk("rst_ov", int'(ov_a), 0);
    chk("rst_val", int'(val_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_sat", int'(sat_a), 0);
    chk("rst_comp", int'(comp_a), 0);
    chk("rst_rdy", int'(rdy_a), 1);
    rst_n = 1'b1;
    step(2);

    // AC extension with 2-cycle latency on the first item
    clear_log();
    send(ac_s[0], ac_c[0], 0, 0);
    chk("lat_1cyc", int'(ov_a), 0);
    in_valid = 1'b0;
    step(1);
    chk("lat_2cyc", int'(ov_a), 1);
    for (int i = 1; i < 6; i++) send(ac_s[i], ac_c[i], 0, 0);
    drain();
    for (int i = 0; i < 6; i++) chk_log("ac_const", i, ac_exp[i]);

    // DC accumulation per component
    clear_log();
    send(2, 3, 1, 0);
    send(1, 0, 1, 0);
    send(3, 4, 1, 1);
    drain();
    chk_log("dc_first", 0, 3);
    chk_log("dc_accum", 1, 2);
    chk_log("dc_comp1", 2, 4);

    // clear between items
    clear_log();
    pred_clear = 1'b1;
    step(1);
    pred_clear = 1'b0;
    send(1, 1, 1, 0);
    drain();
    chk_log("clear_then_dc", 0, 1);

    // clear coincident with a stage-2 DC load
    clear_log();
    send(2, 3, 1, 0);
    in_valid = 1'b0;
    pred_clear = 1'b1;
    step(1);
    pred_clear = 1'b0;
    send(1, 1, 1, 0);
    drain();
    chk_log("clear_coinc_old", 0, 4);
    chk_log("clear_coinc_new", 1, 1);

    // backpressure with out_ready pattern 1,0,0,1
    clear_log();
    for (int i = 0; i < 8; i++) begin
      bp_s[i] = $urandom_range(1, 12);
      bp_c[i] = $urandom_range(0, 4095);
    end
    bp_mode = 1;
    for (int i = 0; i < 8; i++) send(bp_s[i], bp_c[i], 0, 1);
    in_valid = 1'b0;
    step(1);
    bp_mode = 0;
    drain();
    chk("bp_count", log_a.size(), 8);
    for (int i = 0; i < 8; i++) chk_log("bp_order", i, ext_val(bp_s[i], bp_c[i]));

    // illegal size and 13-bit saturation
    clear_log();
    send(13, 5, 1, 2);
    send(12, 12'hFFF, 1, 2);
    send(12, 12'hFFF, 1, 2);
    drain();
    if (log_b.size() == 3) begin
      chk("err_flag", int'(log_eb[0]), 1);
      chk("err_val", log_b[0], 0);
      chk("sat_first", log_b[1], 4095);
      chk("sat_first_flag", int'(log_sb[1]), 0);
      chk("sat_second", log_b[2], 4095);
      chk("sat_second_flag", int'(log_sb[2]), 1);
    end else chk("errsat_count", log_b.size(), 3);

    // reset with both stages full
    out_ready = 1'b0;
    send(3, 1, 0, 0);
    send(3, 6, 1, 1);
    in_valid = 1'b0;
    chk("full_rdy", int'(rdy_a), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", int'(ov_a), 0);
    chk("midrst_ov13", int'(ov_b), 0);
    exp_q.delete();
    pa = '{0, 0, 0};
    pb = '{0, 0, 0};
    step(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(1);
    clear_log();
    send(1, 1, 1, 0);
    drain();
    chk("post_rst_count", log_a.size(), 1);
    chk_log("post_rst_dc", 0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_size    = 4'($urandom_range(0, 14));
      in_code    = 12'($urandom_range(0, 4095));
      in_is_dc   = ($urandom_range(0, 1) == 1);
      in_comp    = 2'($urandom_range(0, 2));
      pred_clear = out_ready && ($urandom_range(0, 39) == 0);
      step(1);
    end
    pred_clear = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
